// File: rtl/alu_packet_pkg.sv
// Shared opcodes, FSM state encodings and header constants for the
// packet-driven ALU engine and its accumulator.
package alu_packet_pkg;

    localparam int HDR_LEN_C = 4;

    typedef enum logic [7:0] {
        OP_ECHO = 8'hEC,
        OP_ADD  = 8'hA0,
        OP_MUL  = 8'hA1,
        OP_XOR  = 8'hA2
    } opcode_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR     = 3'd1;
    localparam state_t ST_CHECK   = 3'd2;
    localparam state_t ST_ECHO    = 3'd3;
    localparam state_t ST_OPND    = 3'd4;
    localparam state_t ST_DISCARD = 3'd5;
    localparam state_t ST_ERR     = 3'd6;
    localparam state_t ST_RESULT  = 3'd7;

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_MUL) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/alu_packet_acc.sv
// Operand byte assembly (little-endian) and the registered accumulator;
// the accumulator updates on the cycle an operand's last byte arrives.
module alu_packet_acc
    import alu_packet_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         strobe_i,
    input  logic         load_i,
    input  opcode_e      op_i,
    input  logic [7:0]   byte_i,
    output logic [W-1:0] result_o,
    output logic         opnd_done_o
);
    localparam int NB = W / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [W-1:0]  opnd;
    logic [CW-1:0] cnt_q, cnt_d;

    // New bytes enter at the top so the first byte ends up as the LSB.
    if (W > 8) begin : g_wide
        assign opnd = {byte_i, sr_q[W-1:8]};
    end else begin : g_byte
        assign opnd = byte_i;
    end

    assign opnd_done_o = strobe_i && (cnt_q == CW'(NB - 1));
    assign result_o    = acc_q;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (strobe_i) begin
            sr_d  = opnd;
            cnt_d = opnd_done_o ? '0 : cnt_q + CW'(1);
            if (opnd_done_o) begin
                if (load_i) begin
                    acc_d = opnd;
                end else begin
                    case (op_i)
                        OP_ADD:  acc_d = acc_q + opnd;
                        OP_MUL:  acc_d = acc_q * opnd;
                        OP_XOR:  acc_d = acc_q ^ opnd;
                        default: acc_d = opnd;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_packet_engine.sv
// Framed command packet engine: header parse, length/opcode checking,
// echo pass-through, multi-operand ALU, error byte and inter-byte timeout.
//
// state   | meaning
// IDLE    | waiting for opcode byte
// HDR     | collecting reserved + LEN bytes
// CHECK   | one cycle to validate header
// ECHO    | payload forwarded rx -> tx
// OPND    | operand bytes into accumulator
// DISCARD | swallowing payload of a rejected packet
// ERR     | emitting the error byte
// RESULT  | emitting result bytes, LSB first
module alu_packet_engine
    import alu_packet_pkg::*;
#(
    parameter int         OPERAND_WIDTH_P = 32,
    parameter int         MAX_LEN_P       = 256,
    parameter int         TIMEOUT_P       = 100000,
    parameter logic [7:0] ERR_BYTE_P      = 8'hEE,
    parameter int         ERR_CNT_WIDTH_P = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [7:0]                 rx_data_i,
    input  logic                       rx_valid_i,
    output logic                       rx_ready_o,
    output logic [7:0]                 tx_data_o,
    output logic                       tx_valid_o,
    input  logic                       tx_ready_i,
    output logic                       busy_o,
    output logic [ERR_CNT_WIDTH_P-1:0] err_count_o
);
    localparam int NB = OPERAND_WIDTH_P / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P + 1) : 1;

    state_t                     state_q, state_d;
    logic [1:0]                 hdr_idx_q, hdr_idx_d;
    logic [7:0]                 opcode_q, opcode_d;
    logic [15:0]                len_q, len_d;
    logic [15:0]                remain_q, remain_d;
    logic [CW-1:0]              res_idx_q, res_idx_d;
    logic                       first_q, first_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [ERR_CNT_WIDTH_P-1:0] err_q, err_d;

    logic                       rx_xfer, tx_xfer, timed, tmo_fire, err_inc;
    logic                       len_bad, alu_op, op_known, shape_bad;
    logic [15:0]                payload;
    logic                       acc_strobe, acc_done, acc_clr;
    logic [OPERAND_WIDTH_P-1:0] acc_result;

    always_comb begin
        rx_ready_o = 1'b0;
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
        if (!rst_i) begin
            case (state_q)
                ST_IDLE, ST_HDR, ST_OPND, ST_DISCARD: rx_ready_o = 1'b1;
                ST_ECHO: begin
                    rx_ready_o = tx_ready_i;
                    tx_valid_o = rx_valid_i;
                    tx_data_o  = rx_data_i;
                end
                ST_RESULT: begin
                    tx_valid_o = 1'b1;
                    tx_data_o  = acc_result[{res_idx_q, 3'b000} +: 8];
                end
                ST_ERR: begin
                    tx_valid_o = 1'b1;
                    tx_data_o  = ERR_BYTE_P;
                end
                default: ;
            endcase
        end
    end

    assign rx_xfer     = rx_valid_i && rx_ready_o;
    assign tx_xfer     = tx_valid_o && tx_ready_i;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_count_o = err_q;

    assign timed    = (state_q == ST_HDR) || (state_q == ST_OPND) ||
                      (state_q == ST_ECHO) || (state_q == ST_DISCARD);
    // Down-counter reloads on every rx transfer; terminal count is 1.
    assign tmo_fire = (TIMEOUT_P != 0) && timed && !rx_xfer && (tmo_q == TW'(1));
    assign tmo_d    = (timed && !rx_xfer) ? tmo_q - TW'(1) : TW'(TIMEOUT_P);

    assign payload   = len_q - 16'(HDR_LEN_C);
    assign len_bad   = (len_q < 16'(HDR_LEN_C)) || (len_q > 16'(MAX_LEN_P));
    assign alu_op    = is_alu_op(opcode_q);
    assign op_known  = alu_op || (opcode_q == OP_ECHO);
    assign shape_bad = alu_op && ((payload == 16'd0) || ((payload % 16'(NB)) != 16'd0));
    assign acc_clr   = (state_q == ST_CHECK);

    always_comb begin
        state_d    = state_q;
        hdr_idx_d  = hdr_idx_q;
        opcode_d   = opcode_q;
        len_d      = len_q;
        remain_d   = remain_q;
        res_idx_d  = res_idx_q;
        first_d    = first_q;
        acc_strobe = 1'b0;
        err_inc    = 1'b0;
        case (state_q)
            ST_IDLE: if (rx_xfer) begin
                opcode_d  = rx_data_i;
                hdr_idx_d = 2'd1;
                state_d   = ST_HDR;
            end
            ST_HDR: if (rx_xfer) begin
                hdr_idx_d = hdr_idx_q + 2'd1;
                if (hdr_idx_q == 2'd2) len_d[7:0] = rx_data_i;
                if (hdr_idx_q == 2'd3) begin
                    len_d[15:8] = rx_data_i;
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                remain_d  = payload;
                first_d   = 1'b1;
                res_idx_d = '0;
                if (len_bad)                    state_d = ST_ERR;
                else if (!op_known || shape_bad) state_d = (payload == 16'd0) ? ST_ERR : ST_DISCARD;
                else if (opcode_q == OP_ECHO)   state_d = (payload == 16'd0) ? ST_IDLE : ST_ECHO;
                else                            state_d = ST_OPND;
            end
            ST_ECHO, ST_DISCARD: if (rx_xfer) begin
                remain_d = remain_q - 16'd1;
                if (remain_q == 16'd1) state_d = (state_q == ST_ECHO) ? ST_IDLE : ST_ERR;
            end
            ST_OPND: if (rx_xfer) begin
                acc_strobe = 1'b1;
                remain_d   = remain_q - 16'd1;
                if (acc_done)          first_d = 1'b0;
                if (remain_q == 16'd1) state_d = ST_RESULT;
            end
            ST_RESULT: if (tx_xfer) begin
                if (res_idx_q == CW'(NB - 1)) state_d = ST_IDLE;
                else                          res_idx_d = res_idx_q + CW'(1);
            end
            ST_ERR: if (tx_xfer) begin
                err_inc = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (tmo_fire) begin
            err_inc = 1'b1;
            state_d = ST_IDLE;
        end
    end

    assign err_d = (err_inc && (err_q != {ERR_CNT_WIDTH_P{1'b1}})) ? err_q + 1'b1 : err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hdr_idx_q <= '0;
            opcode_q  <= '0;
            len_q     <= '0;
            remain_q  <= '0;
            res_idx_q <= '0;
            first_q   <= 1'b0;
            tmo_q     <= TW'(TIMEOUT_P);
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            hdr_idx_q <= hdr_idx_d;
            opcode_q  <= opcode_d;
            len_q     <= len_d;
            remain_q  <= remain_d;
            res_idx_q <= res_idx_d;
            first_q   <= first_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    alu_packet_acc #(.W(OPERAND_WIDTH_P)) u_acc (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (acc_clr),
        .strobe_i    (acc_strobe),
        .load_i      (first_q),
        .op_i        (opcode_e'(opcode_q)),
        .byte_i      (rx_data_i),
        .result_o    (acc_result),
        .opnd_done_o (acc_done)
    );

endmodule

// File: tb/tb_alu_packet_engine.sv
// Scoreboard bench for alu_packet_engine: packet-level reference model feeds an
// expected-byte queue that an independent tx monitor drains and compares.
module tb_alu_packet_engine;
    localparam int W    = 32;
    localparam int MAXL = 256;
    localparam int TMO  = 50;

    typedef logic [7:0] bytes_t[$];

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_valid_i = 1'b0;
    logic       rx_ready_o;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i = 1'b1;
    logic       busy_o;
    logic [7:0] err_count_o;

    int         n_checks = 0;
    int         n_fail = 0;
    int         exp_err = 0;
    int         rdy_mode = 0;
    logic [7:0] exp_q[$];
    logic       mon_stall = 1'b0;
    logic [7:0] mon_data = 8'h00;

    alu_packet_engine #(
        .OPERAND_WIDTH_P (W),
        .MAX_LEN_P       (MAXL),
        .TIMEOUT_P       (TMO),
        .ERR_BYTE_P      (8'hEE),
        .ERR_CNT_WIDTH_P (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .busy_o      (busy_o),
        .err_count_o (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: packet in, expected response bytes and error count out.
    function automatic void model_pkt(input bytes_t p);
        int          len;
        int          pl;
        logic [31:0] acc;
        logic [31:0] opnd;
        len = {p[3], p[2]};
        acc = 0;
        if (len < 4 || len > MAXL) begin
            exp_q.push_back(8'hEE);
            if (exp_err < 255) exp_err++;
            return;
        end
        pl = len - 4;
        if (p[0] == 8'hEC) begin
            for (int i = 0; i < pl; i++) exp_q.push_back(p[4+i]);
        end else if ((p[0] == 8'hA0 || p[0] == 8'hA1 || p[0] == 8'hA2) && pl > 0 && pl % 4 == 0) begin
            for (int k = 0; k < pl / 4; k++) begin
                opnd = {p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]};
                if (k == 0)             acc = opnd;
                else if (p[0] == 8'hA0) acc = acc + opnd;
                else if (p[0] == 8'hA1) acc = acc * opnd;
                else                    acc = acc ^ opnd;
            end
            for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
        end else begin
            exp_q.push_back(8'hEE);
            if (exp_err < 255) exp_err++;
        end
    endfunction

    // Downstream ready pattern: 0 always ready, 1 toggling, 2 manual, 3 random.
    initial forever begin
        @(posedge clk_i);
        #1;
        case (rdy_mode)
            0: tx_ready_i = 1'b1;
            1: tx_ready_i = ~tx_ready_i;
            3: tx_ready_i = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    initial forever begin
        @(negedge clk_i);
        if (rst_i) begin
            mon_stall = 1'b0;
        end else begin
            if (mon_stall) begin
                chk("tx_hold_valid", tx_valid_o, 1);
                chk("tx_hold_data", tx_data_o, mon_data);
            end
            if (tx_valid_o && tx_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: actual=%0h required=none", tx_data_o);
                end else begin
                    chk("tx_byte", tx_data_o, exp_q.pop_front());
                end
            end
            mon_stall = tx_valid_o && !tx_ready_i;
            mon_data  = tx_data_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk_i);
            acc = rx_ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!acc) chk("rx_accept", acc, 1);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_pkt(input bytes_t p, input int gmax);
        foreach (p[i]) begin
            send_byte(p[i]);
            repeat ($urandom_range(0, gmax)) begin
                @(posedge clk_i);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk_i);
            if (!busy_o && exp_q.size() == 0) done = 1'b1;
        end
        chk({name, "_idle"}, done, 1);
        chk({name, "_errcnt"}, err_count_o, exp_err);
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_pkt(input string name, input bytes_t p, input int gmax);
        model_pkt(p);
        send_pkt(p, gmax);
        wait_idle(name);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t p;
        int     kind, len, k;
        logic   seen;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_rx_ready", rx_ready_o, 0);
        chk("rst_tx_valid", tx_valid_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_rx_ready", rx_ready_o, 1);
        chk("idle_tx_valid", tx_valid_o, 0);
        chk("idle_tx_data", tx_data_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_errcnt", err_count_o, 0);
        @(posedge clk_i);
        #1;

        p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        run_pkt("echo", p, 0);
        p = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
              8'h02, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_pkt("add_wrap", p, 0);
        rdy_mode = 1;
        p = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h03, 8'h00, 8'h01, 8'h00};
        run_pkt("mul_bp", p, 0);
        rdy_mode = 0;
        p = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h11, 8'h22, 8'h33};
        run_pkt("bad_shape", p, 0);
        p = '{8'h5A, 8'h00, 8'h05, 8'h00, 8'h99};
        run_pkt("bad_opcode", p, 0);
        p = '{8'hEC, 8'h00, 8'h04, 8'h00};
        run_pkt("echo_empty", p, 0);
        p = '{8'hA2, 8'h00, 8'h04, 8'h00};
        run_pkt("alu_empty", p, 0);
        p = '{8'hEC, 8'h00, 8'h03, 8'h00};
        run_pkt("len_short", p, 0);

        p = '{8'hEC, 8'h00, 8'h00, 8'h01};
        for (int i = 0; i < MAXL - 4; i++) p.push_back(8'($urandom));
        run_pkt("echo_maxlen", p, 0);
        p = '{8'hEC, 8'h00, 8'h01, 8'h01};
        run_pkt("len_over", p, 0);

        // Inter-byte timeout mid-operand: aborts silently after TMO idle cycles.
        p = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h01};
        send_pkt(p, 0);
        repeat (TMO - 5) @(posedge clk_i);
        @(negedge clk_i);
        chk("tmo_still_busy", busy_o, 1);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("tmo_idle", busy_o, 0);
        chk("tmo_rx_ready", rx_ready_o, 1);
        if (exp_err < 255) exp_err++;
        chk("tmo_errcnt", err_count_o, exp_err);
        @(posedge clk_i);
        #1;
        p = '{8'hA2, 8'h00, 8'h0C, 8'h00, 8'hF0, 8'h0F, 8'h55, 8'hAA,
              8'h0F, 8'hF0, 8'hFF, 8'h00};
        run_pkt("xor_after_tmo", p, 0);

        rdy_mode = 3;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            p = {};
            if (kind <= 2) begin
                len = 4 + $urandom_range(0, 12);
                p.push_back(8'hEC);
            end else if (kind <= 6) begin
                k   = $urandom_range(1, 4);
                len = 4 + 4 * k;
                p.push_back(8'(8'hA0 + $urandom_range(0, 2)));
            end else if (kind == 7) begin
                len = 4 + $urandom_range(0, 14);
                if (len > 4 && (len - 4) % 4 == 0) len++;
                p.push_back(8'(8'hA0 + $urandom_range(0, 2)));
            end else if (kind == 8) begin
                len = 4 + $urandom_range(0, 6);
                p.push_back(8'($urandom_range(0, 255)));
                if (p[0] == 8'hEC || p[0] == 8'hA0 || p[0] == 8'hA1 || p[0] == 8'hA2) p[0] = 8'h5A;
            end else begin
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : MAXL + 1 + $urandom_range(0, 100);
                p.push_back(8'($urandom_range(0, 255)));
                if (p[0] == 8'h5A) p[0] = 8'hA1;
            end
            p.push_back(8'($urandom));
            p.push_back(len[7:0]);
            p.push_back(len[15:8]);
            if (len >= 4 && len <= MAXL)
                for (int i = 0; i < len - 4; i++) p.push_back(8'($urandom));
            run_pkt("random", p, 2);
        end

        // Reset in the middle of a result after two bytes have gone out.
        rdy_mode   = 2;
        tx_ready_i = 1'b0;
        p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
              8'h01, 8'h00, 8'h00, 8'h00};
        model_pkt(p);
        send_pkt(p, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            seen = tx_valid_o;
        end
        chk("rst_mid_result_valid", seen, 1);
        @(posedge clk_i);
        #1 tx_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        tx_ready_i = 1'b0;
        rst_i      = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_mid_tx_valid", tx_valid_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_errcnt", err_count_o, 0);
        chk("rst_mid_acc", dut.u_acc.acc_q, 0);
        chk("rst_mid_rx_ready", rx_ready_o, 0);
        chk("rst_mid_bytes_left", exp_q.size(), 2);
        exp_q.delete();
        exp_err = 0;
        rst_i   = 1'b0;
        @(negedge clk_i);
        chk("post_rst_rx_ready", rx_ready_o, 1);
        chk("post_rst_tx_valid", tx_valid_o, 0);
        @(posedge clk_i);
        #1 rdy_mode = 0;
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h7E};
        run_pkt("post_rst_echo", p, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
